// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control unit: FSM states,
// opcode constants, opcode classes and the immediate, next-PC and writeback
// select encodings.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CL_OP      = 4'd0,
    CL_OPIMM   = 4'd1,
    CL_LOAD    = 4'd2,
    CL_STORE   = 4'd3,
    CL_BRANCH  = 4'd4,
    CL_JAL     = 4'd5,
    CL_JALR    = 4'd6,
    CL_LUI     = 4'd7,
    CL_AUIPC   = 4'd8,
    CL_ILLEGAL = 4'd9
  } op_class_e;

  // Opcodes (instr[6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Immediate generator formats
  localparam logic [2:0] IMM_R  = 3'b000;
  localparam logic [2:0] IMM_I  = 3'b001;
  localparam logic [2:0] IMM_B  = 3'b010;
  localparam logic [2:0] IMM_J1 = 3'b011;
  localparam logic [2:0] IMM_J2 = 3'b100;
  localparam logic [2:0] IMM_U  = 3'b101;
  localparam logic [2:0] IMM_S  = 3'b111;

  // Next-PC source
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  // Register writeback source
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

endpackage

// File: rtl/op_decode.sv
// Combinational opcode classifier.
//   opcode_i  : instr[6:0]
//   class_o   : instruction class (CL_ILLEGAL for unlisted opcodes)
//   imm_sel_o : immediate format for the immediate generator
//   legal_o   : 1 when the opcode is one the controller executes
module op_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output op_class_e  class_o,
  output logic [2:0] imm_sel_o,
  output logic       legal_o
);

  always_comb begin
    class_o   = CL_ILLEGAL;
    imm_sel_o = IMM_R;
    legal_o   = 1'b1;
    case (opcode_i)
      OPC_OP:     begin class_o = CL_OP;     imm_sel_o = IMM_R;  end
      OPC_OPIMM:  begin class_o = CL_OPIMM;  imm_sel_o = IMM_I;  end
      OPC_LOAD:   begin class_o = CL_LOAD;   imm_sel_o = IMM_I;  end
      OPC_STORE:  begin class_o = CL_STORE;  imm_sel_o = IMM_S;  end
      OPC_BRANCH: begin class_o = CL_BRANCH; imm_sel_o = IMM_B;  end
      OPC_JAL:    begin class_o = CL_JAL;    imm_sel_o = IMM_J1; end
      OPC_JALR:   begin class_o = CL_JALR;   imm_sel_o = IMM_J2; end
      OPC_LUI:    begin class_o = CL_LUI;    imm_sel_o = IMM_U;  end
      OPC_AUIPC:  begin class_o = CL_AUIPC;  imm_sel_o = IMM_U;  end
      default:    legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   instr        : instruction register contents
//   imem_ready   : instruction fetch complete (IR loads this cycle)
//   dmem_ready   : data access complete
//   br_taken     : branch comparator result, sampled in EXEC
//   imem_req     : instruction fetch request
//   ir_we        : IR load strobe
//   dmem_req     : data memory request, dmem_we = store
//   imm_sel      : immediate format select
//   pc_we/pc_sel : PC update strobe and next-PC source
//   rf_we/wb_sel : register write strobe and writeback source
//   trap         : sticky illegal-opcode / memory timeout indication
// TIMEOUT bounds the wait for imem_ready/dmem_ready; 0 waits forever.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        br_taken,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [2:0]  imm_sel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        trap
);

  localparam bit          TO_EN    = (TIMEOUT != 0);
  localparam int unsigned CW       = TO_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned LAST     = TO_EN ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAST);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  op_class_e  op_class;
  logic [2:0] dec_imm_sel;
  logic       op_legal;

  // Only the opcode field steers control; the rest of the IR feeds the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[31:7];

  op_decode u_op_decode (
    .opcode_i  (instr[6:0]),
    .class_o   (op_class),
    .imm_sel_o (dec_imm_sel),
    .legal_o   (op_legal)
  );

  // The wait budget expires on the cycle in which the counter already holds
  // TIMEOUT-1 waits; a ready arriving in that same cycle takes priority.
  logic wait_expired;
  assign wait_expired = TO_EN && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    imm_sel  = IMM_R;
    pc_we    = 1'b0;
    pc_sel   = PC_PLUS4;
    rf_we    = 1'b0;
    wb_sel   = WB_ALU;
    trap     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (wait_expired) begin
          state_d = ST_TRAP;
        end else if (TO_EN) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DECODE: begin
        imm_sel = dec_imm_sel;
        state_d = op_legal ? ST_EXEC : ST_TRAP;
      end

      ST_EXEC: begin
        imm_sel = dec_imm_sel;
        case (op_class)
          CL_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = br_taken ? PC_IMM : PC_PLUS4;
            state_d = ST_FETCH;
          end
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          default:           state_d = ST_WB;
        endcase
      end

      ST_MEM: begin
        imm_sel  = dec_imm_sel;
        dmem_req = 1'b1;
        dmem_we  = (op_class == CL_STORE);
        if (dmem_ready) begin
          if (op_class == CL_STORE) begin
            pc_we   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (wait_expired) begin
          state_d = ST_TRAP;
        end else if (TO_EN) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_WB: begin
        imm_sel = dec_imm_sel;
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = ST_FETCH;
        case (op_class)
          CL_JAL:  pc_sel = PC_IMM;
          CL_JALR: pc_sel = PC_ALU;
          default: pc_sel = PC_PLUS4;
        endcase
        case (op_class)
          CL_LOAD:         wb_sel = WB_MEM;
          CL_JAL, CL_JALR: wb_sel = WB_PC4;
          CL_LUI:          wb_sel = WB_IMM;
          default:         wb_sel = WB_ALU;
        endcase
      end

      ST_TRAP: trap = 1'b1;

      default: state_d = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. For each instruction the bench
// builds the expected per-cycle output trace from the instruction's class,
// the chosen ready delays and the branch outcome, and compares it cycle by
// cycle. Inputs that the current phase must ignore are driven randomly.
module tb_multicycle_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = '0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic        imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we, trap;
  logic [2:0]  imm_sel;
  logic [1:0]  pc_sel, wb_sel;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .br_taken   (br_taken),
    .imem_req   (imem_req),
    .ir_we      (ir_we),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .imm_sel    (imm_sel),
    .pc_we      (pc_we),
    .pc_sel     (pc_sel),
    .rf_we      (rf_we),
    .wb_sel     (wb_sel),
    .trap       (trap)
  );

  logic [13:0] obs;
  assign obs = {imem_req, ir_we, dmem_req, dmem_we, imm_sel,
                pc_we, pc_sel, rf_we, wb_sel, trap};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] vec(input bit ireq, input bit irwe, input bit dreq,
                                      input bit dwe, input logic [2:0] imm, input bit pcwe,
                                      input logic [1:0] psel, input bit rfwe,
                                      input logic [1:0] wsel, input bit trp);
    return {ireq, irwe, dreq, dwe, imm, pcwe, psel, rfwe, wsel, trp};
  endfunction

  // Instruction-class facts straight from the ISA table.
  function automatic bit is_legal(input logic [6:0] o);
    case (o)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] exp_imm(input logic [6:0] o);
    case (o)
      7'b0010011, 7'b0000011: return 3'b001;
      7'b1100011:             return 3'b010;
      7'b1101111:             return 3'b011;
      7'b1100111:             return 3'b100;
      7'b0110111, 7'b0010111: return 3'b101;
      7'b0100011:             return 3'b111;
      default:                return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] exp_wb(input logic [6:0] o);
    case (o)
      7'b0000011:             return 2'd1;
      7'b1101111, 7'b1100111: return 2'd2;
      7'b0110111:             return 2'd3;
      default:                return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] exp_pc_wb(input logic [6:0] o);
    if (o == 7'b1101111) return 2'd1;
    if (o == 7'b1100111) return 2'd2;
    return 2'd0;
  endfunction

  // One clock cycle: outputs compared at the falling edge, then advance to
  // just after the next rising edge.
  task automatic step(input logic [13:0] e, input string tag);
    @(negedge clk);
    check(tag, 32'(obs), 32'(e));
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset: outputs must show FETCH before any clock edge.
  task automatic do_reset(input string tag);
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    br_taken   = 1'b0;
    rst = 1'b1;
    #2;
    check(tag, 32'(obs), 32'(vec(1,0,0,0,3'b000,0,2'd0,0,2'd0,0)));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Runs one instruction. fd/md = wait cycles before imem_ready/dmem_ready.
  task automatic run_instr(input logic [31:0] ins, input int unsigned fd,
                           input int unsigned md, input bit taken, input string tag);
    logic [6:0] opc;
    logic [2:0] imm;
    bit         mem, st, br;
    opc = ins[6:0];
    imm = exp_imm(opc);
    mem = (opc == 7'b0000011) || (opc == 7'b0100011);
    st  = (opc == 7'b0100011);
    br  = (opc == 7'b1100011);
    instr = ins;
    for (int unsigned i = 0; i <= fd; i++) begin
      imem_ready = (i == fd);
      dmem_ready = 1'($urandom);
      br_taken   = 1'($urandom);
      step(vec(1, i == fd, 0,0,3'b000,0,2'd0,0,2'd0,0), {tag, "/fetch"});
    end
    imem_ready = 1'($urandom);
    step(vec(0,0,0,0,imm,0,2'd0,0,2'd0,0), {tag, "/decode"});
    if (!is_legal(opc)) begin
      for (int unsigned t = 0; t < 20; t++) begin
        imem_ready = 1'($urandom);
        dmem_ready = 1'($urandom);
        step(vec(0,0,0,0,3'b000,0,2'd0,0,2'd0,1), {tag, "/trap"});
      end
      return;
    end
    if (br) begin
      br_taken = taken;
      step(vec(0,0,0,0,imm,1,taken ? 2'd1 : 2'd0,0,2'd0,0), {tag, "/exec_br"});
      return;
    end
    br_taken = 1'($urandom);
    step(vec(0,0,0,0,imm,0,2'd0,0,2'd0,0), {tag, "/exec"});
    if (mem) begin
      imem_ready = 1'($urandom);
      for (int unsigned j = 0; j <= md; j++) begin
        dmem_ready = (j == md);
        step(vec(0,0,1,st,imm, st && (j == md), 2'd0,0,2'd0,0), {tag, "/mem"});
      end
      dmem_ready = 1'b0;
      if (st) return;
    end
    dmem_ready = 1'($urandom);
    step(vec(0,0,0,0,imm,1,exp_pc_wb(opc),1,exp_wb(opc),0), {tag, "/wb"});
    dmem_ready = 1'b0;
  endtask

  logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                7'b0010111};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [6:0]  opc;
    #1;
    do_reset("reset_state");

    run_instr(32'h00500093, 0, 0, 1'b0, "addi");
    run_instr(32'h0000A103, 0, 3, 1'b0, "lw");
    run_instr(32'h00208463, 0, 0, 1'b1, "beq_taken");
    run_instr(32'h00208463, 1, 0, 1'b0, "beq_not");
    run_instr(32'h000080E7, 2, 0, 1'b0, "jalr");
    run_instr(32'h0020A423, 1, 2, 1'b0, "sw");

    run_instr(32'h0000007F, 0, 0, 1'b0, "illegal");
    do_reset("trap_rst");

    // Fetch timeout: four unanswered FETCH cycles, then TRAP.
    instr = 32'h00500093;
    for (int unsigned i = 0; i < TO; i++) begin
      imem_ready = 1'b0;
      step(vec(1,0,0,0,3'b000,0,2'd0,0,2'd0,0), "ito/fetch");
    end
    for (int unsigned i = 0; i < 3; i++)
      step(vec(0,0,0,0,3'b000,0,2'd0,0,2'd0,1), "ito/trap");
    do_reset("ito_rst");

    // Ready in the last permitted cycle wins over the timeout.
    run_instr(32'h00500093, TO - 1, 0, 1'b0, "ito_edge");
    run_instr(32'h0000A103, 0, TO - 1, 1'b0, "dto_edge");

    // Data timeout on a load.
    instr = 32'h0000A103;
    imem_ready = 1'b1;
    step(vec(1,1,0,0,3'b000,0,2'd0,0,2'd0,0), "dto/fetch");
    imem_ready = 1'b0;
    step(vec(0,0,0,0,3'b001,0,2'd0,0,2'd0,0), "dto/decode");
    step(vec(0,0,0,0,3'b001,0,2'd0,0,2'd0,0), "dto/exec");
    for (int unsigned i = 0; i < TO; i++)
      step(vec(0,0,1,0,3'b001,0,2'd0,0,2'd0,0), "dto/mem");
    step(vec(0,0,0,0,3'b000,0,2'd0,0,2'd0,1), "dto/trap");
    do_reset("dto_rst");

    // Reset during a store access; a late dmem_ready must be ignored.
    instr = 32'h0020A423;
    imem_ready = 1'b1;
    step(vec(1,1,0,0,3'b000,0,2'd0,0,2'd0,0), "abort/fetch");
    imem_ready = 1'b0;
    step(vec(0,0,0,0,3'b111,0,2'd0,0,2'd0,0), "abort/decode");
    step(vec(0,0,0,0,3'b111,0,2'd0,0,2'd0,0), "abort/exec");
    step(vec(0,0,1,1,3'b111,0,2'd0,0,2'd0,0), "abort/mem");
    do_reset("abort_rst");
    dmem_ready = 1'b1;
    step(vec(1,0,0,0,3'b000,0,2'd0,0,2'd0,0), "abort/late_ready");
    dmem_ready = 1'b0;
    run_instr(32'h00500093, 0, 0, 1'b0, "after_abort");

    // Randomized instruction stream, with occasional illegal opcodes.
    for (int unsigned k = 0; k < 60; k++) begin
      r = $urandom;
      if ($urandom_range(0, 7) == 0)
        opc = 7'($urandom);
      else
        opc = legal_ops[$urandom_range(0, 8)];
      run_instr({r[31:7], opc}, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1),
                1'($urandom), "rand");
      if (!is_legal(opc))
        do_reset("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
